// File: rtl/pulse_stretcher_pkg.sv
// rtl/pulse_stretcher_pkg.sv - shared state type and counter-width helper for pulse_stretcher
package pulse_stretcher_pkg;

  typedef enum logic [1:0] {IDLE, HOLD, GAP} ps_state_t;

  function automatic int ps_cnt_w(int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pulse_stretcher_if.sv
// rtl/pulse_stretcher_if.sv - event strobe in, press level and queue status out
interface pulse_stretcher_if #(parameter int PW = 3);

  logic          pulse;
  logic          press;
  logic          busy;
  logic [PW-1:0] pending;
  logic          overflow;

  modport master (output pulse, input press, busy, pending, overflow);
  modport slave  (input pulse, output press, busy, pending, overflow);

endinterface

// File: rtl/pulse_stretcher_cycle_timer.sv
// rtl/pulse_stretcher_cycle_timer.sv - loadable down-counter, done while at zero
module cycle_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// rtl/pulse_stretcher.sv - stretches event strobes into hold/gap press periods with a pending queue
// Optional sticky overflow flag: define PULSE_STRETCHER_OVF_EN.
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int MAX_PENDING = 7
) (
  input logic              clk,
  input logic              rst_n,
  pulse_stretcher_if.slave bus
);

  localparam int PW   = ps_cnt_w(MAX_PENDING);
  localparam int TMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int TW   = ps_cnt_w(TMAX);
  localparam logic [TW-1:0] HOLD_LD  = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LD   = TW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PENDING);

  ps_state_t     state;
  logic          press_q;
  logic          busy_q;
  logic [PW-1:0] pending_q;

  logic          timer_done;
  logic          timer_load;
  logic [TW-1:0] timer_val;
  logic          gap_end;
  logic          has_pend;
  logic          dequeue;
  logic          direct;
  logic          enqueue;

  // A strobe on the last gap cycle with an empty queue starts the next hold directly.
  always_comb begin
    gap_end    = (state == GAP) && timer_done;
    has_pend   = (pending_q != '0);
    dequeue    = gap_end && has_pend;
    direct     = gap_end && !has_pend && bus.pulse;
    enqueue    = bus.pulse && (state != IDLE) && !direct;
    timer_load = 1'b0;
    timer_val  = HOLD_LD;
    case (state)
      IDLE: timer_load = bus.pulse;
      HOLD: begin
        timer_load = timer_done;
        timer_val  = GAP_LD;
      end
      GAP:  timer_load = timer_done && (has_pend || bus.pulse);
      default: ;
    endcase
  end

  cycle_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      press_q   <= 1'b0;
      busy_q    <= 1'b0;
      pending_q <= '0;
    end else begin
      case (state)
        IDLE: if (bus.pulse) begin
          state   <= HOLD;
          press_q <= 1'b1;
          busy_q  <= 1'b1;
        end
        HOLD: if (timer_done) begin
          state   <= GAP;
          press_q <= 1'b0;
        end
        GAP: if (timer_done) begin
          if (has_pend || bus.pulse) begin
            state   <= HOLD;
            press_q <= 1'b1;
          end else begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          press_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
      if (enqueue && !dequeue && (pending_q != PEND_MAX)) begin
        pending_q <= pending_q + 1'b1;
      end else if (dequeue && !enqueue) begin
        pending_q <= pending_q - 1'b1;
      end
    end
  end

`ifdef PULSE_STRETCHER_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (enqueue && !dequeue && (pending_q == PEND_MAX)) begin
      ovf_q <= 1'b1;
    end
  end

  assign bus.overflow = ovf_q;
`else
  assign bus.overflow = 1'b0;
`endif

  assign bus.press   = press_q;
  assign bus.busy    = busy_q;
  assign bus.pending = pending_q;

endmodule
